jzjpcc_memory_arbiter: RTL and testbench

Shares the single-ported instruction/data SRAM between the fetch stage and the memory stage of the pipelined core. Each cycle it grants at most one requester and drives the SRAM port. It returns read data one cycle later, tagged to the correct requester. It also generates the stall signals that hold a losing stage in place.

---
 rtl/jzjpcc_memory_arbiter_if.sv | 57 +++++
 rtl/jzjpcc_memory_arbiter.sv | 86 ++++++++
 tb/tb_jzjpcc_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jzjpcc_memory_arbiter_if.sv
// jzjpcc_memory_arbiter_if: request/grant bus shared by the fetch stage, the
// memory stage and the single-ported SRAM. The arbiter is the slave side. The
// pipeline stages and the SRAM together form the master side.
//
// Handshake: a requester raises *Request with its address/attributes. A
// *Grant seen in the same cycle means the access is issued at the next rising
// edge. A requester that sees no grant is stalled and keeps its request up.
// For a granted read, *Valid rises exactly one cycle later with the data.
interface jzjpcc_memory_arbiter_if #(
  parameter int RAM_A_WIDTH = 12,
  parameter int PC_MAX_B    = RAM_A_WIDTH + 1
);
  // fetch port
  logic                  fetchRequest;
  logic [PC_MAX_B:2]     fetchAddress;
  logic                  fetchGrant;
  logic                  fetchValid;
  logic [31:0]           fetchData;
  // data port
  logic                  dataRequest;
  logic                  dataWrite;
  logic [PC_MAX_B:2]     dataAddress;
  logic [3:0]            dataByteEnable;
  logic [31:0]           dataWriteData;
  logic                  dataGrant;
  logic                  dataValid;
  logic [31:0]           dataReadData;
  // SRAM port
  logic [RAM_A_WIDTH-1:0] ramAddress;
  logic                  ramWriteEnable;
  logic [3:0]            ramByteEnable;
  logic [31:0]           ramWriteData;
  logic [31:0]           ramReadData;
  // stalls
  logic                  stall_fetch;
  logic                  stall_memory;

  modport slave (
    input  fetchRequest, fetchAddress,
    output fetchGrant, fetchValid, fetchData,
    input  dataRequest, dataWrite, dataAddress, dataByteEnable, dataWriteData,
    output dataGrant, dataValid, dataReadData,
    output ramAddress, ramWriteEnable, ramByteEnable, ramWriteData,
    input  ramReadData,
    output stall_fetch, stall_memory
  );

  modport master (
    output fetchRequest, fetchAddress,
    input  fetchGrant, fetchValid, fetchData,
    output dataRequest, dataWrite, dataAddress, dataByteEnable, dataWriteData,
    input  dataGrant, dataValid, dataReadData,
    input  ramAddress, ramWriteEnable, ramByteEnable, ramWriteData,
    output ramReadData,
    input  stall_fetch, stall_memory
  );
endinterface

// File: rtl/jzjpcc_memory_arbiter.sv
// jzjpcc_memory_arbiter: shares one SRAM port between fetch and memory stage.
// Data wins contested cycles. When the macro JZJPCC_ARBITER_STARVATION_GUARD_EN
// is defined, a streak counter forces a fetch grant after MAX_DATA_STREAK
// consecutive contested data wins. Read data returns one cycle after grant.
module jzjpcc_memory_arbiter #(
  parameter int RAM_A_WIDTH     = 12,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                    clock,
  input logic                    reset,
  jzjpcc_memory_arbiter_if.slave bus
);

  logic       w_fetch_grant;
  logic       w_data_grant;
  logic       w_force_fetch;
  logic [1:0] r_tag;  // {fetch, load} issued at the previous edge

`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

  logic [3:0] r_streak;

  assign w_force_fetch = (r_streak == STREAK_LIMIT);

  // Count data wins while fetch waits; clear on fetch grant or idle fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (!bus.fetchRequest || w_fetch_grant) begin
      r_streak <= '0;
    end else if (w_data_grant && (r_streak != STREAK_LIMIT)) begin
      r_streak <= r_streak + 4'd1;
    end
  end
`else
  assign w_force_fetch = 1'b0;
`endif

  // Pick at most one winner; nothing is granted while reset is low.
  always_comb begin
    w_fetch_grant = 1'b0;
    w_data_grant  = 1'b0;
    if (reset) begin
      if (bus.dataRequest && !(bus.fetchRequest && w_force_fetch)) begin
        w_data_grant = 1'b1;
      end else if (bus.fetchRequest) begin
        w_fetch_grant = 1'b1;
      end
    end
  end

  // Drive the SRAM port from the winner; the fetch address parks there when idle.
  always_comb begin
    bus.ramAddress     = bus.fetchAddress[RAM_A_WIDTH+1:2];
    bus.ramWriteEnable = 1'b0;
    bus.ramByteEnable  = 4'b0000;
    if (w_data_grant) begin
      bus.ramAddress = bus.dataAddress[RAM_A_WIDTH+1:2];
      if (bus.dataWrite) begin
        bus.ramWriteEnable = 1'b1;
        bus.ramByteEnable  = bus.dataByteEnable;
      end
    end
  end

  // Remember who owns the SRAM read data arriving next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag <= 2'b00;
    end else begin
      r_tag <= {w_fetch_grant, w_data_grant & ~bus.dataWrite};
    end
  end

  assign bus.ramWriteData = bus.dataWriteData;
  assign bus.fetchGrant   = w_fetch_grant;
  assign bus.dataGrant    = w_data_grant;
  assign bus.fetchValid   = r_tag[1];
  assign bus.dataValid    = r_tag[0];
  assign bus.fetchData    = bus.ramReadData;
  assign bus.dataReadData = bus.ramReadData;
  assign bus.stall_fetch  = bus.fetchRequest & ~w_fetch_grant;
  assign bus.stall_memory = bus.dataRequest & ~w_data_grant;

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// tb_jzjpcc_memory_arbiter: directed and random traffic against the arbiter,
// with a behavioural SRAM and a scoreboard of expected read words.
module tb_jzjpcc_memory_arbiter;

  localparam int RAM_A_WIDTH = 12;
  localparam int PC_MAX_B    = 15;  // wider than the SRAM so aliasing is visible
  localparam int MAX_STREAK  = 4;
  localparam int AW          = PC_MAX_B - 1;  // width of [PC_MAX_B:2]
`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
  localparam int EXP_CONTEST_FETCHES = 3;  // d d d d f, three times in 15 cycles
`else
  localparam int EXP_CONTEST_FETCHES = 0;
`endif

  logic clock;
  logic reset;

  jzjpcc_memory_arbiter_if #(.RAM_A_WIDTH(RAM_A_WIDTH), .PC_MAX_B(PC_MAX_B)) bus ();

  jzjpcc_memory_arbiter #(
    .RAM_A_WIDTH     (RAM_A_WIDTH),
    .MAX_DATA_STREAK (MAX_STREAK)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- SRAM environment ----------------
  logic [31:0] mem     [0:(1<<RAM_A_WIDTH)-1];
  logic [31:0] exp_mem [0:(1<<RAM_A_WIDTH)-1];

  always @(posedge clock) begin
    bus.ramReadData <= mem[bus.ramAddress];
    if (bus.ramWriteEnable) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ramByteEnable[b]) mem[bus.ramAddress][8*b +: 8] <= bus.ramWriteData[8*b +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_data_q[$];
  int          m_streak = 0;
  logic        m_prev_f = 1'b0;
  logic        m_prev_d = 1'b0;
  int          fg_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Checks every cycle on the falling edge, away from the active edge.
  always @(negedge clock) begin
    logic        force_f, exp_fg, exp_dg, exp_we;
    logic [11:0] exp_addr;
    logic [3:0]  exp_be;
    if (bus.fetchGrant === 1'b1) fg_count++;
    if (!reset) begin
      check("rst_fgrant", bus.fetchGrant, 1'b0);
      check("rst_dgrant", bus.dataGrant, 1'b0);
      check("rst_stall_f", bus.stall_fetch, bus.fetchRequest);
      check("rst_stall_m", bus.stall_memory, bus.dataRequest);
      check("rst_fvalid", bus.fetchValid, 1'b0);
      check("rst_dvalid", bus.dataValid, 1'b0);
      check("rst_we", bus.ramWriteEnable, 1'b0);
      m_streak = 0;
      m_prev_f = 1'b0;
      m_prev_d = 1'b0;
      exp_fetch_q.delete();
      exp_data_q.delete();
    end else begin
      // responses for last cycle's grants
      check("fvalid", bus.fetchValid, m_prev_f);
      check("dvalid", bus.dataValid, m_prev_d);
      if (m_prev_f) begin
        check("fq_nonempty", exp_fetch_q.size() != 0, 1'b1);
        if (exp_fetch_q.size() != 0) check("fdata", bus.fetchData, exp_fetch_q.pop_front());
      end
      if (m_prev_d) begin
        check("dq_nonempty", exp_data_q.size() != 0, 1'b1);
        if (exp_data_q.size() != 0) check("ddata", bus.dataReadData, exp_data_q.pop_front());
      end
      // this cycle's arbitration
`ifdef JZJPCC_ARBITER_STARVATION_GUARD_EN
      force_f = (m_streak == MAX_STREAK);
`else
      force_f = 1'b0;
`endif
      exp_dg   = bus.dataRequest && !(bus.fetchRequest && force_f);
      exp_fg   = bus.fetchRequest && !exp_dg;
      exp_we   = exp_dg && bus.dataWrite;
      exp_be   = exp_we ? bus.dataByteEnable : 4'b0000;
      exp_addr = exp_dg ? bus.dataAddress[13:2] : bus.fetchAddress[13:2];
      check("fgrant", bus.fetchGrant, exp_fg);
      check("dgrant", bus.dataGrant, exp_dg);
      check("stall_f", bus.stall_fetch, bus.fetchRequest && !exp_fg);
      check("stall_m", bus.stall_memory, bus.dataRequest && !exp_dg);
      check("ram_we", bus.ramWriteEnable, exp_we);
      check("ram_be", bus.ramByteEnable, exp_be);
      check("ram_addr", bus.ramAddress, exp_addr);
      if (exp_we) check("ram_wdata", bus.ramWriteData, bus.dataWriteData);
      // scoreboard pushes and store shadowing
      if (exp_fg) exp_fetch_q.push_back(exp_mem[exp_addr]);
      if (exp_dg && !bus.dataWrite) exp_data_q.push_back(exp_mem[exp_addr]);
      if (exp_we) exp_mem[exp_addr] = merge(exp_mem[exp_addr], bus.dataWriteData, bus.dataByteEnable);
      m_prev_f = exp_fg;
      m_prev_d = exp_dg && !bus.dataWrite;
      if (!bus.fetchRequest || exp_fg) m_streak = 0;
      else if (exp_dg && m_streak < MAX_STREAK) m_streak++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [3:0] be, input logic [31:0] wd);
    bus.fetchRequest   = fr;
    bus.fetchAddress   = fa;
    bus.dataRequest    = dr;
    bus.dataWrite      = dw;
    bus.dataAddress    = da;
    bus.dataByteEnable = be;
    bus.dataWriteData  = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'b0000, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt0;
    for (int i = 0; i < (1 << RAM_A_WIDTH); i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end
    mem[0]  = 32'h0000_00A0;  exp_mem[0]  = 32'h0000_00A0;
    mem[1]  = 32'h0000_00A1;  exp_mem[1]  = 32'h0000_00A1;
    mem[16] = 32'h1234_5678;  exp_mem[16] = 32'h1234_5678;

    // reset held with both ports requesting
    reset = 1'b0;
    drive(1'b1, 14'h0, 1'b1, 1'b0, 14'h3, 4'b0000, 32'h0);
    repeat (3) @(negedge clock);
    check("rst_both_stall", {bus.stall_fetch, bus.stall_memory}, 2'b11);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_dgrant", bus.dataGrant, 1'b1);
    @(posedge clock); #1;

    // fetch-only reads
    idle(); cycle();
    drive(1'b1, 14'h0, 1'b0, 1'b0, '0, 4'b0000, 32'h0); cycle();
    drive(1'b1, 14'h1, 1'b0, 1'b0, '0, 4'b0000, 32'h0);
    @(negedge clock);
    check("fetch0_data", bus.fetchData, 32'hA0);
    @(posedge clock); #1;
    idle();
    @(negedge clock);
    check("fetch1_data", bus.fetchData, 32'hA1);
    @(posedge clock); #1;

    // partial store then load
    drive(1'b0, '0, 1'b1, 1'b1, 14'h10, 4'b0011, 32'hDEAD_BEEF); cycle();
    drive(1'b0, '0, 1'b1, 1'b0, 14'h10, 4'b1111, 32'h0);         cycle();
    idle();
    @(negedge clock);
    check("load_valid", bus.dataValid, 1'b1);
    check("store_merge", bus.dataReadData, 32'h1234_BEEF);
    @(posedge clock); #1;

    // contested run: both ports request loads every cycle
    cycle();
    cnt0 = fg_count;
    drive(1'b1, 14'h2, 1'b1, 1'b0, 14'h10, 4'b0000, 32'h0);
    repeat (15) cycle();
    check("contest_fetch_cnt", fg_count - cnt0, EXP_CONTEST_FETCHES);
    idle(); cycle();

    // load, then reset pulse in its response cycle
    drive(1'b0, '0, 1'b1, 1'b0, 14'h20, 4'b0000, 32'h0); cycle();
    reset = 1'b0;
    idle();
    @(negedge clock);
    check("rst_kill_dvalid", bus.dataValid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("no_reissue", bus.dataValid, 1'b0);
    @(posedge clock); #1;

    // address aliasing above the SRAM size
    drive(1'b1, 14'(4096 + 5), 1'b0, 1'b0, '0, 4'b0000, 32'h0);
    @(negedge clock);
    check("wrap_ram_addr", bus.ramAddress, 12'd5);
    @(posedge clock); #1;
    idle(); cycle();

    // random mixed traffic over a small window plus aliased high bits
    repeat (300) begin
      drive(1'($urandom_range(0, 1)),
            14'({$urandom_range(0, 3), 12'($urandom_range(0, 31))}),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            14'({$urandom_range(0, 3), 12'($urandom_range(0, 31))}),
            4'($urandom_range(0, 15)),
            $urandom);
      cycle();
    end

    idle();
    repeat (2) cycle();
    check("fq_drain", exp_fetch_q.size(), 0);
    check("dq_drain", exp_data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
